dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the pipelined CPU's data port and main memory. It accepts word read/write requests from the core, answers hits in the request cycle, and stalls the core with `cache_rdy` low while it runs the write-back and refill sequence on a misses. It is the responder for the core's `mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`/`mem_din`/`cache_rdy` interface.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_store.sv | 54 +++++
 rtl/dcache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared state type and address-geometry helpers for the direct-mapped data cache.
package dcache_pkg;
    localparam int unsigned AddrW        = 32;
    localparam int unsigned ByteOffW     = 2;
    localparam int unsigned DefLineWords = 4;
    localparam int unsigned DefLines     = 64;

    typedef enum logic [1:0] {StIdle, StWb, StRefill, StFilled} state_t;

    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned line_words,
                                              input int unsigned lines);
        return AddrW - ByteOffW - off_width(line_words) - idx_width(lines);
    endfunction
endpackage

// File: rtl/dcache_store.sv
// Line storage: per-line tag/valid/dirty flops and a word-addressed data array
// with one combinational read port and one word write port, both at `idx`.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DefLineWords,
    parameter int unsigned LINES      = DefLines,
    localparam int unsigned OffW      = off_width(LINE_WORDS),
    localparam int unsigned IdxW      = idx_width(LINES),
    localparam int unsigned TagW      = tag_width(LINE_WORDS, LINES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IdxW-1:0] idx,
    output logic [TagW-1:0] tag,
    output logic            valid,
    output logic            dirty,
    input  logic [OffW-1:0] rd_off,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [OffW-1:0] wr_off,
    input  logic [31:0]     wr_data,
    input  logic            set_dirty,
    input  logic            install,
    input  logic [TagW-1:0] install_tag
);
    logic [TagW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    assign tag     = tag_q[idx];
    assign valid   = valid_q[idx];
    assign dirty   = dirty_q[idx];
    assign rd_data = data_q[idx][rd_off];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (install) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (install) tag_q[idx] <= install_tag;
        if (wr_en) data_q[idx][wr_off] <= wr_data;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hits answer
// combinationally, misses stall the core while the victim is written back and the line refilled.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DefLineWords,
    parameter int unsigned LINES      = DefLines
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cache_rdy,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int unsigned OffW = off_width(LINE_WORDS);
    localparam int unsigned IdxW = idx_width(LINES);
    localparam int unsigned TagW = tag_width(LINE_WORDS, LINES);
    localparam logic [OffW-1:0] LastCnt = OffW'(LINE_WORDS - 1);

    state_t          state_q, state_d;
    logic [OffW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TagW-1:0] miss_tag_q, miss_tag_d;
    logic [IdxW-1:0] miss_idx_q, miss_idx_d;
    logic            mem_cs_d, mem_we_d;
    logic [31:0]     mem_addr_d, mem_wdata_d;

    logic [TagW-1:0] cpu_tag, st_tag;
    logic [IdxW-1:0] cpu_idx, st_idx;
    logic [OffW-1:0] cpu_off, rd_off, wr_off;
    logic [31:0]     rd_data, wr_data;
    logic            st_valid, st_dirty, wr_en, set_dirty, install;
    logic            req, hit;
    logic            unused_byte_off;

    assign cpu_off         = cpu_addr[ByteOffW +: OffW];
    assign cpu_idx         = cpu_addr[ByteOffW + OffW +: IdxW];
    assign cpu_tag         = cpu_addr[AddrW-1 -: TagW];
    assign unused_byte_off = ^cpu_addr[ByteOffW-1:0];
    assign cnt_inc         = cnt_q + 1'b1;

    // The miss index is latched so a dropped request still completes its line.
    assign st_idx    = (state_q == StIdle) ? cpu_idx : miss_idx_q;
    assign req       = cpu_ren | cpu_wen;
    assign hit       = st_valid && (st_tag == cpu_tag);
    assign cache_rdy = (state_q == StIdle) && (!req || hit);
    assign cpu_rdata = ((state_q == StIdle) && req && hit) ? rd_data : '0;

    dcache_store #(
        .LINE_WORDS(LINE_WORDS),
        .LINES     (LINES)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .idx        (st_idx),
        .tag        (st_tag),
        .valid      (st_valid),
        .dirty      (st_dirty),
        .rd_off     (rd_off),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_off     (wr_off),
        .wr_data    (wr_data),
        .set_dirty  (set_dirty),
        .install    (install),
        .install_tag(miss_tag_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        mem_cs_d    = mem_cs;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rd_off      = cpu_off;
        wr_en       = 1'b0;
        wr_off      = cpu_off;
        wr_data     = cpu_wdata;
        set_dirty   = 1'b0;
        install     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    wr_en     = cpu_wen;
                    set_dirty = cpu_wen;
                end else if (req) begin
                    miss_tag_d = cpu_tag;
                    miss_idx_d = cpu_idx;
                    cnt_d      = '0;
                    mem_cs_d   = 1'b1;
                    rd_off     = '0;
                    if (st_valid && st_dirty) begin
                        state_d     = StWb;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {st_tag, cpu_idx, {OffW{1'b0}}, 2'b00};
                        mem_wdata_d = rd_data;
                    end else begin
                        state_d    = StRefill;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {cpu_tag, cpu_idx, {OffW{1'b0}}, 2'b00};
                    end
                end
            end
            StWb: begin
                // Prefetch the next victim word so it is ready when this one is acked.
                rd_off = cnt_inc;
                if (mem_ack) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LastCnt) begin
                        state_d    = StRefill;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {miss_tag_q, miss_idx_q, {OffW{1'b0}}, 2'b00};
                    end else begin
                        mem_addr_d  = {st_tag, miss_idx_q, cnt_inc, 2'b00};
                        mem_wdata_d = rd_data;
                    end
                end
            end
            StRefill: begin
                if (mem_ack) begin
                    wr_en   = 1'b1;
                    wr_off  = cnt_q;
                    wr_data = mem_rdata;
                    cnt_d   = cnt_inc;
                    if (cnt_q == LastCnt) begin
                        install  = 1'b1;
                        mem_cs_d = 1'b0;
                        mem_we_d = 1'b0;
                        state_d  = StFilled;
                    end else begin
                        mem_addr_d = {miss_tag_q, miss_idx_q, cnt_inc, 2'b00};
                    end
                end
            end
            StFilled: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            mem_cs     <= mem_cs_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a flat-memory
// reference with a per-index residency model and a latency-programmable memory responder.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ren, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cache_rdy, mem_cs, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINE_WORDS(4), .LINES(64)) dut (
        .clk(clk), .rst(rst), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cache_rdy(cache_rdy), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    txn_t        txn_q[$];
    logic [31:0] mem  [logic [31:0]];
    logic [31:0] gold [logic [31:0]];
    bit          lvalid [64];
    bit          ldirty [64];
    int unsigned ltag   [64];
    int          lat = 1;
    bit          spurious = 0;
    int          stable_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return 32'h1111_0000 + ((a >> 2) - 32'd16);
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : mem_rd(a);
    endfunction

    // Transaction-level expectation for one core access; updates the residency model.
    function automatic void model_step(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                       output int exp_stall, output logic [31:0] exp_rd,
                                       output bit wb, output logic [31:0] wb_base);
        int unsigned idx;
        int unsigned tg;
        idx = (a >> 4) % 64;
        tg  = a >> 10;
        exp_stall = 0;
        wb = 0;
        wb_base = 0;
        exp_rd = gold_rd(a);
        if (!(lvalid[idx] && ltag[idx] == tg)) begin
            exp_stall = 2 + 4 * lat;
            if (lvalid[idx] && ldirty[idx]) begin
                wb = 1;
                wb_base = (32'(ltag[idx]) << 10) | (32'(idx) << 4);
                exp_stall += 4 * lat;
            end
            lvalid[idx] = 1;
            ltag[idx] = tg;
            ldirty[idx] = 0;
        end
        if (wr) begin
            gold[a] = wd;
            ldirty[idx] = 1;
        end
    endfunction

    // Dirty lines are lost on reset: the core sees memory contents again.
    function automatic void model_reset();
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            if (lvalid[i] && ldirty[i]) begin
                for (int w = 0; w < 4; w++) begin
                    a = (32'(ltag[i]) << 10) | (32'(i) << 4) | (32'(w) << 2);
                    gold[a] = mem_rd(a);
                end
            end
            lvalid[i] = 0;
            ldirty[i] = 0;
        end
    endfunction

    // Memory responder: acks after `lat` cycles of mem_cs, logs every completed word.
    initial begin
        int          wait_cnt;
        logic [31:0] held_addr;
        logic        held_we;
        wait_cnt = 0;
        held_addr = 0;
        held_we = 0;
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (!rst) begin
                wait_cnt = 0;
            end else if (mem_cs) begin
                if (wait_cnt == 0) begin
                    held_addr = mem_addr;
                    held_we = mem_we;
                end else if (mem_addr !== held_addr || mem_we !== held_we) begin
                    stable_err++;
                end
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    mem_ack = 1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        txn_q.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                        txn_q.push_back({1'b0, mem_addr, mem_rdata});
                    end
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
                if (spurious) begin
                    mem_ack = 1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Called just after a posedge; returns the number of cycles cache_rdy stayed low.
    task automatic cpu_access(input bit ren, input bit wen, input logic [31:0] addr,
                              input logic [31:0] wdata, output int stall,
                              output logic [31:0] rdata);
        cpu_ren = ren;
        cpu_wen = wen;
        cpu_addr = addr;
        cpu_wdata = wdata;
        stall = 0;
        while (1) begin
            @(negedge clk);
            if (cache_rdy || stall > 400) break;
            stall++;
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_ren = 0;
        cpu_wen = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        cpu_ren = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cache_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", cache_rdy); else n_pass++;
        n_checks++; if (mem_cs !== 1'b0) $display("FAIL reset_cs: got %b want 0", mem_cs); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", cpu_rdata); else n_pass++;
        rst = 1;
        @(posedge clk);
        #1;
        n_checks++; if (cache_rdy !== 1'b1 || mem_cs !== 1'b0)
            $display("FAIL post_reset: got rdy=%b cs=%b want rdy=1 cs=0", cache_rdy, mem_cs); else n_pass++;
    endtask

    task automatic test_refill();
        int st, es; logic [31:0] rd, er, wbb; bit wb;
        lat = 1;
        txn_q.delete();
        model_step(32'h40, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'h40, 0, st, rd);
        n_checks++; if (st !== 6) $display("FAIL refill_stall: got %0d want 6", st); else n_pass++;
        n_checks++; if (rd !== 32'h1111_0000) $display("FAIL refill_rdata: got %h want 11110000", rd); else n_pass++;
        n_checks++; if (txn_q.size() !== 4) $display("FAIL refill_count: got %0d want 4", txn_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < txn_q.size(); i++) begin
            n_checks++;
            if (txn_q[i].we !== 1'b0 || txn_q[i].addr !== 32'h40 + 32'(4 * i))
                $display("FAIL refill_addr%0d: got we=%b %h want we=0 %h", i, txn_q[i].we,
                         txn_q[i].addr, 32'h40 + 32'(4 * i));
            else n_pass++;
        end
        model_step(32'h44, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'h44, 0, st, rd);
        n_checks++; if (st !== 0) $display("FAIL hit_stall: got %0d want 0", st); else n_pass++;
        n_checks++; if (rd !== 32'h1111_0001) $display("FAIL hit_rdata: got %h want 11110001", rd); else n_pass++;
    endtask

    task automatic test_write_hit();
        int st, es; logic [31:0] rd, er, wbb, ed; bit wb;
        txn_q.delete();
        model_step(32'h48, 1, 32'hDEAD_BEEF, es, er, wb, wbb);
        cpu_access(0, 1, 32'h48, 32'hDEAD_BEEF, st, rd);
        n_checks++; if (st !== 0 || txn_q.size() !== 0)
            $display("FAIL wr_hit: got stall=%0d txns=%0d want 0 0", st, txn_q.size()); else n_pass++;
        model_step(32'h448, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'h448, 0, st, rd);
        n_checks++; if (st !== 10) $display("FAIL wb_stall: got %0d want 10", st); else n_pass++;
        n_checks++; if (rd !== 32'h1111_0102) $display("FAIL wb_rdata: got %h want 11110102", rd); else n_pass++;
        n_checks++; if (txn_q.size() !== 8) $display("FAIL wb_count: got %0d want 8", txn_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < txn_q.size(); i++) begin
            ed = (i == 2) ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(i);
            n_checks++;
            if (i < 4 && (txn_q[i].we !== 1'b1 || txn_q[i].addr !== 32'h40 + 32'(4 * i) ||
                          txn_q[i].data !== ed))
                $display("FAIL wb_word%0d: got we=%b %h %h want we=1 %h %h", i, txn_q[i].we,
                         txn_q[i].addr, txn_q[i].data, 32'h40 + 32'(4 * i), ed);
            else if (i >= 4 && (txn_q[i].we !== 1'b0 || txn_q[i].addr !== 32'h430 + 32'(4 * i)))
                $display("FAIL wb_refill%0d: got we=%b %h want we=0 %h", i, txn_q[i].we,
                         txn_q[i].addr, 32'h430 + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_write_miss();
        int st, es; logic [31:0] rd, er, wbb; bit wb;
        txn_q.delete();
        model_step(32'h800, 1, 32'h1234_5678, es, er, wb, wbb);
        cpu_access(0, 1, 32'h800, 32'h1234_5678, st, rd);
        n_checks++; if (st !== 6) $display("FAIL wmiss_stall: got %0d want 6", st); else n_pass++;
        n_checks++; if (txn_q.size() !== 4 || txn_q[0].addr !== 32'h800 || txn_q[3].addr !== 32'h80C)
            $display("FAIL wmiss_refill: got %0d txns want 0x800..0x80C", txn_q.size()); else n_pass++;
        txn_q.delete();
        model_step(32'hC00, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'hC00, 0, st, rd);
        n_checks++; if (st !== 10) $display("FAIL wmiss_wb_stall: got %0d want 10", st); else n_pass++;
        n_checks++; if (rd !== er) $display("FAIL wmiss_rdata: got %h want %h", rd, er); else n_pass++;
        n_checks++; if (mem_rd(32'h800) !== 32'h1234_5678)
            $display("FAIL wmiss_wb_data: got %h want 12345678", mem_rd(32'h800)); else n_pass++;
    endtask

    task automatic test_slow_mem();
        int st, es, bad; logic [31:0] rd, er, wbb; bit wb;
        lat = 3;
        stable_err = 0;
        txn_q.delete();
        model_step(32'h1004, 1, 32'hCAFE_0001, es, er, wb, wbb);
        cpu_access(0, 1, 32'h1004, 32'hCAFE_0001, st, rd);
        n_checks++; if (st !== 14) $display("FAIL slow_stall: got %0d want 14", st); else n_pass++;
        n_checks++; if (stable_err !== 0) $display("FAIL slow_stable: got %0d changes want 0", stable_err); else n_pass++;
        spurious = 1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (mem_cs || !cache_rdy) bad++;
        end
        spurious = 0;
        @(posedge clk);
        #1;
        n_checks++; if (bad !== 0) $display("FAIL spurious_idle: got %0d bad cycles want 0", bad); else n_pass++;
        model_step(32'h1004, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'h1004, 0, st, rd);
        n_checks++; if (st !== 0 || rd !== 32'hCAFE_0001)
            $display("FAIL spurious_hit: got stall=%0d %h want 0 cafe0001", st, rd); else n_pass++;
        n_checks++; if (txn_q.size() !== 4) $display("FAIL spurious_txns: got %0d want 4", txn_q.size()); else n_pass++;
        lat = 1;
    endtask

    task automatic test_both();
        int st, es; logic [31:0] rd, er, wbb; bit wb;
        txn_q.delete();
        model_step(32'h1008, 1, 32'hB0B0_0008, es, er, wb, wbb);
        cpu_access(1, 1, 32'h1008, 32'hB0B0_0008, st, rd);
        n_checks++; if (st !== 0 || txn_q.size() !== 0)
            $display("FAIL both_hit: got stall=%0d txns=%0d want 0 0", st, txn_q.size()); else n_pass++;
        cpu_access(1, 0, 32'h1008, 0, st, rd);
        n_checks++; if (rd !== 32'hB0B0_0008) $display("FAIL both_readback: got %h want b0b00008", rd); else n_pass++;
        model_step(32'h1400, 1, 32'hB0B0_1400, es, er, wb, wbb);
        cpu_access(1, 1, 32'h1400, 32'hB0B0_1400, st, rd);
        n_checks++; if (st !== 10) $display("FAIL both_miss_stall: got %0d want 10", st); else n_pass++;
        cpu_access(1, 0, 32'h1400, 0, st, rd);
        n_checks++; if (rd !== 32'hB0B0_1400) $display("FAIL both_miss_data: got %h want b0b01400", rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int st, es, guard; logic [31:0] rd, er, wbb; bit wb;
        lat = 1;
        txn_q.delete();
        cpu_ren = 1; cpu_wen = 0; cpu_addr = 32'h2040; cpu_wdata = 0;
        guard = 0;
        while (txn_q.size() < 1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        n_checks++; if (guard >= 50) $display("FAIL rmid_wait: got no ack want one"); else n_pass++;
        @(posedge clk);
        #2;
        n_checks++; if (mem_addr !== 32'h2044 || mem_cs !== 1'b1)
            $display("FAIL rmid_word1: got cs=%b %h want cs=1 00002044", mem_cs, mem_addr); else n_pass++;
        rst = 0;
        #1;
        n_checks++; if (mem_cs !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL rmid_async: got cs=%b %h want cs=0 0", mem_cs, mem_addr); else n_pass++;
        cpu_ren = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        model_step(32'h2040, 0, 0, es, er, wb, wbb);
        cpu_access(1, 0, 32'h2040, 0, st, rd);
        n_checks++; if (st !== 6) $display("FAIL rmid_remiss: got stall=%0d want 6", st); else n_pass++;
        n_checks++; if (rd !== er) $display("FAIL rmid_rdata: got %h want %h", rd, er); else n_pass++;
    endtask

    task automatic test_random();
        int st, es, op, nexp; logic [31:0] a, wd, rd, er, wbb; bit wb;
        logic [31:0] exp_wb [4];
        for (int n = 0; n < 200; n++) begin
            a   = (32'($urandom_range(3)) << 10) | (32'($urandom_range(3)) << 4) |
                  (32'($urandom_range(3)) << 2);
            op  = $urandom_range(2);
            wd  = $urandom;
            lat = $urandom_range(1, 3);
            model_step(a, op != 0, wd, es, er, wb, wbb);
            for (int w = 0; w < 4; w++) exp_wb[w] = gold_rd(wbb + 32'(4 * w));
            txn_q.delete();
            cpu_access(op != 1, op != 0, a, wd, st, rd);
            nexp = (es == 0) ? 0 : (wb ? 8 : 4);
            n_checks++; if (st !== es) $display("FAIL rnd_stall[%0d] %h: got %0d want %0d", n, a, st, es); else n_pass++;
            n_checks++; if (txn_q.size() !== nexp)
                $display("FAIL rnd_txns[%0d]: got %0d want %0d", n, txn_q.size(), nexp); else n_pass++;
            if (op == 0) begin
                n_checks++; if (rd !== er) $display("FAIL rnd_rdata[%0d] %h: got %h want %h", n, a, rd, er); else n_pass++;
            end
            if (wb) begin
                for (int w = 0; w < 4 && w < txn_q.size(); w++) begin
                    n_checks++;
                    if (txn_q[w].we !== 1'b1 || txn_q[w].addr !== wbb + 32'(4 * w) ||
                        txn_q[w].data !== exp_wb[w])
                        $display("FAIL rnd_wb[%0d.%0d]: got we=%b %h %h want we=1 %h %h", n, w,
                                 txn_q[w].we, txn_q[w].addr, txn_q[w].data, wbb + 32'(4 * w),
                                 exp_wb[w]);
                    else n_pass++;
                end
            end
        end
        lat = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_refill();
        test_write_hit();
        test_write_miss();
        test_slow_mem();
        test_both();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
